// File: rtl/snn_layer.sv
// rtl/snn_layer.sv - parametrised time-to-first-spike LIF layer with leak, saturation and early termination
module snn_layer #(
  parameter int N_IN         = 4,
  parameter int N_OUT        = 4,
  parameter int DTT_WIDTH    = 5,
  parameter int WEIGHT_WIDTH = 4,
  parameter int POT_WIDTH    = 8,
  parameter int WINDOW       = 32,
  parameter int TTD_WIDTH    = 5,
  parameter int LEAK_SHIFT   = 0
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic                                start,
  input  logic [N_IN*DTT_WIDTH-1:0]           input_vector,
  input  logic [N_OUT*N_IN*WEIGHT_WIDTH-1:0]  weights,
  input  logic [POT_WIDTH-1:0]                threshold,
  output logic [N_OUT*TTD_WIDTH-1:0]          output_vector,
  output logic [N_OUT-1:0]                    spike_out,
  output logic                                busy,
  output logic                                finish
);

  // Accumulator wide enough that potential minus leak plus every weight cannot overflow.
  localparam int SUM_W = POT_WIDTH + WEIGHT_WIDTH + $clog2(N_IN + 1) + 2;
  localparam logic signed [SUM_W-1:0] POT_MAX = SUM_W'((64'sd1 <<< (POT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] POT_MIN = -POT_MAX - SUM_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [TTD_WIDTH-1:0]                 t_q, t_d;
  logic [N_IN*DTT_WIDTH-1:0]            in_q, in_d;
  logic [N_OUT*N_IN*WEIGHT_WIDTH-1:0]   w_q, w_d;
  logic signed [POT_WIDTH-1:0]          thr_q, thr_d;
  logic signed [POT_WIDTH-1:0]          pot_q [N_OUT];
  logic signed [POT_WIDTH-1:0]          pot_d [N_OUT];
  logic [N_OUT-1:0]                     fired_q, fired_d;
  logic [N_OUT-1:0]                     spike_q, spike_d;
  logic [N_OUT*TTD_WIDTH-1:0]           ov_q, ov_d;
  logic [N_IN-1:0]                      in_spk;

  // An input spikes in the RUN cycle whose counter equals its latched time; late times never match.
  always_comb begin
    in_spk = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_spk[i] = (state_q == S_RUN) &&
                  (32'(in_q[i*DTT_WIDTH +: DTT_WIDTH]) == 32'(t_q)) &&
                  (32'(in_q[i*DTT_WIDTH +: DTT_WIDTH]) < WINDOW);
    end
  end

  // Next-state, neuron integration, firing and result capture.
  always_comb begin
    logic signed [SUM_W-1:0]     acc;
    logic signed [POT_WIDTH-1:0] lk;
    logic signed [POT_WIDTH-1:0] vnext;
    logic [WEIGHT_WIDTH-1:0]     wv;
    state_d = state_q;
    t_d     = t_q;
    in_d    = in_q;
    w_d     = w_q;
    thr_d   = thr_q;
    fired_d = fired_q;
    spike_d = '0;
    ov_d    = ov_q;
    acc     = '0;
    lk      = '0;
    vnext   = '0;
    wv      = '0;
    for (int o = 0; o < N_OUT; o++) pot_d[o] = pot_q[o];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          in_d    = input_vector;
          w_d     = weights;
          thr_d   = threshold;
          fired_d = '0;
          ov_d    = '0;
          t_d     = '0;
          for (int o = 0; o < N_OUT; o++) pot_d[o] = '0;
        end
      end
      S_RUN: begin
        for (int o = 0; o < N_OUT; o++) begin
          if (!fired_q[o]) begin
            lk  = (LEAK_SHIFT == 0) ? '0 : (pot_q[o] >>> LEAK_SHIFT);
            acc = {{(SUM_W-POT_WIDTH){pot_q[o][POT_WIDTH-1]}}, pot_q[o]}
                - {{(SUM_W-POT_WIDTH){lk[POT_WIDTH-1]}}, lk};
            for (int i = 0; i < N_IN; i++) begin
              wv = w_q[(o*N_IN+i)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
              if (in_spk[i]) acc = acc + {{(SUM_W-WEIGHT_WIDTH){wv[WEIGHT_WIDTH-1]}}, wv};
            end
            if (acc > POT_MAX) acc = POT_MAX;
            else if (acc < POT_MIN) acc = POT_MIN;
            vnext = acc[POT_WIDTH-1:0];
            if ((vnext >= thr_q) || (thr_q <= 0)) begin
              ov_d[o*TTD_WIDTH +: TTD_WIDTH] = t_q;
              spike_d[o] = 1'b1;
              fired_d[o] = 1'b1;
              pot_d[o]   = '0;
            end else begin
              pot_d[o] = vnext;
            end
          end
        end
        if ((&fired_d) || (32'(t_q) == WINDOW - 1)) begin
          state_d = S_DONE;
          for (int o = 0; o < N_OUT; o++) begin
            if (!fired_d[o]) ov_d[o*TTD_WIDTH +: TTD_WIDTH] = '1;
          end
        end else begin
          t_d = t_q + TTD_WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any run and clears every visible output.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      in_q    <= '0;
      w_q     <= '0;
      thr_q   <= '0;
      fired_q <= '0;
      spike_q <= '0;
      ov_q    <= '0;
      for (int o = 0; o < N_OUT; o++) pot_q[o] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      in_q    <= in_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
      fired_q <= fired_d;
      spike_q <= spike_d;
      ov_q    <= ov_d;
      for (int o = 0; o < N_OUT; o++) pot_q[o] <= pot_d[o];
    end
  end

  assign output_vector = ov_q;
  assign spike_out     = spike_q;
  assign busy          = (state_q == S_RUN);
  assign finish        = (state_q == S_DONE);

endmodule

// File: tb/tb_snn_layer.sv
// tb/tb_snn_layer.sv - scoreboard bench for snn_layer with directed vectors
module tb_snn_layer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [19:0] iv;
  logic [63:0] w;
  logic [7:0]  thr8;
  logic [4:0]  thr5;
  logic [19:0] ov0, ov1, ov2, m_ov;
  logic [3:0]  sp0, sp1, sp2, m_sp;
  logic        b0, b1, b2, f0, f1, f2, m_b, m_f;
  int          sel;

  always #5 CLK = ~CLK;

  snn_layer u_dflt (.CLK(CLK), .nRST(nRST), .start(start), .input_vector(iv), .weights(w),
                    .threshold(thr8), .output_vector(ov0), .spike_out(sp0), .busy(b0), .finish(f0));
  snn_layer #(.POT_WIDTH(5)) u_p5 (.CLK(CLK), .nRST(nRST), .start(start), .input_vector(iv), .weights(w),
                    .threshold(thr5), .output_vector(ov1), .spike_out(sp1), .busy(b1), .finish(f1));
  snn_layer #(.LEAK_SHIFT(1)) u_lk (.CLK(CLK), .nRST(nRST), .start(start), .input_vector(iv), .weights(w),
                    .threshold(thr8), .output_vector(ov2), .spike_out(sp2), .busy(b2), .finish(f2));

  always_comb begin
    m_ov = ov0; m_sp = sp0; m_b = b0; m_f = f0;
    if (sel == 1) begin m_ov = ov1; m_sp = sp1; m_b = b1; m_f = f1; end
    if (sel == 2) begin m_ov = ov2; m_sp = sp2; m_b = b2; m_f = f2; end
  end

  typedef struct {
    logic [19:0] ov;
    int          fin_rel;
    int          spk_rel;
    logic [3:0]  spk_val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          spk_rel_seen = 0;
  logic [3:0]  spk_val_seen = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [19:0] ov, input int fin, input int srel, input logic [3:0] sval);
    exp_t e;
    e.ov = ov; e.fin_rel = fin; e.spk_rel = srel; e.spk_val = sval;
    return e;
  endfunction

  // Monitor: tracks first spike of the run and checks results whenever finish is seen.
  always @(negedge CLK) begin
    int   rel;
    exp_t e;
    rel = cyc - start_cyc;
    if (rel == 0) begin spk_rel_seen = 0; spk_val_seen = '0; end
    if (m_sp != 0 && spk_val_seen == 0) begin spk_rel_seen = rel; spk_val_seen = m_sp; end
    if (m_f) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_finish: got finish at rel %0d expected none", rel);
      end else begin
        e = sb.pop_front();
        chk("output_vector", 32'(m_ov), 32'(e.ov));
        chk("finish_latency", rel, e.fin_rel);
        chk("spike_time", spk_rel_seen, e.spk_rel);
        chk("spike_value", 32'(spk_val_seen), 32'(e.spk_val));
        chk("busy_in_done", 32'(m_b), 32'd0);
      end
    end
  end

  task automatic issue(input int s, input logic [19:0] v, input logic [63:0] wt,
                       input logic [7:0] t8, input logic [4:0] t5, input bit push, input exp_t e);
    @(negedge CLK);
    sel = s; iv = v; w = wt; thr8 = t8; thr5 = t5;
    if (push) sb.push_back(e);
    start = 1'b1;
    @(posedge CLK);
    #1 start_cyc = cyc;
    start = 1'b0;
    @(negedge CLK);
    chk("busy_in_run", 32'(m_b), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge CLK); n++; end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  localparam logic [19:0] IV_T1   = {5'd9, 5'd7, 5'd5, 5'd3};
  localparam logic [63:0] W_T1    = 64'h0000_0000_0000_1111;
  localparam logic [19:0] OV_T1   = {5'd31, 5'd31, 5'd31, 5'd5};
  localparam logic [19:0] IV_LK   = {5'd31, 5'd31, 5'd2, 5'd0};
  localparam logic [63:0] W_LK    = 64'h0000_0000_0000_0044;

  initial begin
    nRST = 1'b0; start = 1'b0; sel = 0; iv = '0; w = '0; thr8 = '0; thr5 = '0;
    repeat (2) @(negedge CLK);
    chk("reset_ov", 32'(ov0), 32'd0);
    chk("reset_spike", 32'(sp0), 32'd0);
    chk("reset_busy", 32'(b0), 32'd0);
    chk("reset_finish", 32'(f0), 32'd0);
    nRST = 1'b1;

    issue(0, IV_T1, W_T1, 8'd2, 5'd2, 1'b1, mk(OV_T1, 32, 6, 4'h1));
    wait_done();

    issue(0, 20'd0, 64'h4444_4444_4444_4444, 8'd4, 5'd4, 1'b1, mk(20'd0, 1, 1, 4'hF));
    wait_done();

    issue(1, 20'd0, 64'h7777_7777_7777_7777, 8'd15, 5'd15, 1'b1, mk(20'd0, 1, 1, 4'hF));
    wait_done();

    issue(0, IV_LK, W_LK, 8'd6, 5'd6, 1'b1, mk({5'd31, 5'd31, 5'd31, 5'd2}, 32, 3, 4'h1));
    wait_done();

    issue(2, IV_LK, W_LK, 8'd6, 5'd6, 1'b1, mk({5'd31, 5'd31, 5'd31, 5'd31}, 32, 0, 4'h0));
    wait_done();

    // start re-pulsed mid-run and again during DONE
    issue(0, IV_T1, W_T1, 8'd2, 5'd2, 1'b1, mk(OV_T1, 32, 6, 4'h1));
    repeat (10) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    while (cyc - start_cyc < 32) @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(negedge CLK);
    chk("start_in_done_ignored", 32'(m_b), 32'd0);
    wait_done();

    // reset at t=10 aborts the run
    issue(0, IV_T1, W_T1, 8'd2, 5'd2, 1'b0, mk(OV_T1, 32, 6, 4'h1));
    repeat (10) @(negedge CLK);
    chk("ov_before_reset", 32'(ov0), 32'd5);
    nRST = 1'b0;
    #1;
    chk("abort_ov", 32'(ov0), 32'd0);
    chk("abort_busy", 32'(b0), 32'd0);
    chk("abort_finish", 32'(f0), 32'd0);
    chk("abort_spike", 32'(sp0), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);

    issue(0, IV_T1, W_T1, 8'd2, 5'd2, 1'b1, mk(OV_T1, 32, 6, 4'h1));
    wait_done();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
